// File: rtl/sd_block_responder.sv
// Serves 512-byte SD sector reads/writes from byte-wide backing memory via the sector-buffer handshake.
// Read: 2 cycles/byte, write: 3 cycles/byte, plus one cycle per mem_ack wait; memory stalls hold the FSM in place.
module sd_block_responder #(
  parameter int ADDR_W = 25,
  parameter int BLK_W  = 23
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  input  logic [BLK_W-1:0]  img_blocks,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, ACK, RD_MEM, RD_PUT, WR_ADDR, WR_WAIT, WR_MEM, DONE} state_t;

  // Only the LBA bits that reach mem_addr are kept; the range check uses all 32 at accept time.
  localparam int LBA_W = ADDR_W - 9;

  state_t           state_q, state_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic [8:0]       n_q, n_d;
  logic [8:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             wr_op_q, wr_op_d;
  logic             oob_q, oob_d;
  logic             ack_q, ack_d;
  logic             bwr_q, bwr_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [31:0]      blocks_ext;

  assign blocks_ext = 32'(img_blocks);

  always_comb begin
    state_d = state_q;
    lba_d   = lba_q;
    n_d     = n_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_op_d = wr_op_q;
    oob_d   = oob_q;
    ack_d   = ack_q;
    bwr_d   = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (sd_rd || sd_wr) begin
          lba_d   = sd_lba[LBA_W-1:0];
          wr_op_d = !sd_rd;
          oob_d   = (blocks_ext == 32'd0) || (sd_lba >= blocks_ext);
          err_d   = oob_d;
          state_d = ACK;
        end
      end
      ACK: begin
        ack_d   = 1'b1;
        n_d     = 9'd0;
        addr_d  = 9'd0;
        state_d = wr_op_q ? WR_ADDR : RD_MEM;
      end
      RD_MEM: begin
        if (oob_q) begin
          data_d  = 8'h00;
          state_d = RD_PUT;
        end else if (mem_ack) begin
          data_d  = mem_din;
          state_d = RD_PUT;
        end
      end
      RD_PUT: begin
        // Strobe and address are registered, so they appear alongside the next byte's fetch.
        bwr_d  = 1'b1;
        addr_d = n_q;
        if (n_q == 9'd511) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + 9'd1;
          state_d = RD_MEM;
        end
      end
      WR_ADDR: state_d = WR_WAIT;
      WR_WAIT: begin
        data_d  = sd_buff_din;
        state_d = WR_MEM;
      end
      WR_MEM: begin
        if (oob_q || mem_ack) begin
          if (n_q == 9'd511) begin
            state_d = DONE;
          end else begin
            n_d     = n_q + 9'd1;
            addr_d  = n_q + 9'd1;
            state_d = WR_ADDR;
          end
        end
      end
      DONE: begin
        if (!sd_rd && !sd_wr) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lba_q   <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_op_q <= 1'b0;
      oob_q   <= 1'b0;
      ack_q   <= 1'b0;
      bwr_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lba_q   <= lba_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_op_q <= wr_op_d;
      oob_q   <= oob_d;
      ack_q   <= ack_d;
      bwr_q   <= bwr_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Memory strobes decode straight from state so a reset drops them without waiting for a clock.
  assign mem_rd       = (state_q == RD_MEM) && !oob_q;
  assign mem_wr       = (state_q == WR_MEM) && !oob_q;
  assign mem_addr     = {lba_q, n_q};
  assign mem_dout     = data_q;
  assign sd_ack       = ack_q;
  assign sd_buff_addr = addr_q;
  assign sd_buff_dout = data_q;
  assign sd_buff_wr   = bwr_q;
  assign busy         = busy_q;
  assign err          = err_q;
endmodule

// File: tb/tb_sd_block_responder.sv
// Randomised bench for sd_block_responder: a sector-level model queues the expected buffer
// and memory traffic, monitors pop and compare as the DUT produces it.
module tb_sd_block_responder;
  localparam int ADDR_W = 25;
  localparam int BLK_W  = 23;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic [31:0]       sd_lba = '0;
  logic              sd_rd = 1'b0;
  logic              sd_wr = 1'b0;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din = '0;
  logic [BLK_W-1:0]  img_blocks = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din = '0;
  logic              mem_ack = 1'b0;
  logic              busy;
  logic              err;

  sd_block_responder #(.ADDR_W(ADDR_W), .BLK_W(BLK_W)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .img_blocks(img_blocks),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack), .busy(busy), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {int addr; int data;} ev_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   max_lat = 0;
  int   bw_count = 0;
  int   first_bw_cyc = 0;
  int   last_bw_cyc = 0;
  int   last_mem_cyc = 0;
  int   ack_rises = 0;
  bit   ack_prev = 1'b0;
  ev_t  exp_bw[$];
  ev_t  exp_mw[$];
  int   exp_mr[$];
  logic [7:0] ref_mem [int];
  logic [7:0] sim_mem [int];
  logic [7:0] bbuf [512];

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mem_init(int a);
    return (a & 255) ^ 'h5A;
  endfunction

  function automatic int ref_rd(int a);
    return ref_mem.exists(a) ? int'(ref_mem[a]) : mem_init(a);
  endfunction

  function automatic int sim_rd(int a);
    return sim_mem.exists(a) ? int'(sim_mem[a]) : mem_init(a);
  endfunction

  function automatic int byte_addr(logic [31:0] lba, int i);
    longint full;
    full = longint'(lba) * 512 + longint'(i);
    return int'(full % (64'd1 << ADDR_W));
  endfunction

  // Sector-level reference: what the transfer must do to buffer and memory.
  task automatic model_req(input bit is_wr, input logic [31:0] lba, input logic [31:0] blocks,
                           output bit oob);
    ev_t e;
    oob = (blocks == 0) || (lba >= blocks);
    for (int i = 0; i < 512; i++) begin
      e.addr = byte_addr(lba, i);
      if (!is_wr) begin
        e.data = oob ? 0 : ref_rd(e.addr);
        if (!oob) exp_mr.push_back(e.addr);
        e.addr = i;
        exp_bw.push_back(e);
      end else if (!oob) begin
        e.data = int'(bbuf[i]);
        ref_mem[e.addr] = bbuf[i];
        exp_mw.push_back(e);
      end
    end
  endtask

  always @(posedge clk_sys) cyc++;

  // Registered sector-buffer dpram: address to sampled data is two clocks.
  always @(posedge clk_sys) sd_buff_din <= bbuf[sd_buff_addr];

  // Buffer-side monitor.
  always @(negedge clk_sys) begin
    ev_t e;
    if (sd_ack && !ack_prev) ack_rises++;
    ack_prev = sd_ack;
    if (sd_buff_wr) begin
      bbuf[sd_buff_addr] = sd_buff_dout;
      if (bw_count == 0) first_bw_cyc = cyc;
      last_bw_cyc = cyc;
      bw_count++;
      if (exp_bw.size() == 0) chk("bw_unexpected", 1, 0);
      else begin
        e = exp_bw.pop_front();
        chk("bw_addr", sd_buff_addr, e.addr);
        chk("bw_data", sd_buff_dout, e.data);
      end
    end
    if (mem_rd || mem_wr) chk("rd_wr_excl", mem_rd && mem_wr, 0);
  end

  // Memory responder and monitor with random ack latency.
  int   wcnt = -1;
  bit   pend = 1'b0;
  logic [ADDR_W-1:0] pend_addr = '0;
  always @(negedge clk_sys) begin
    ev_t e;
    int  a;
    if (mem_ack) begin
      mem_ack = 1'b0;
      pend = 1'b0;
    end else if (!(mem_rd || mem_wr)) begin
      wcnt = -1;
      pend = 1'b0;
    end else begin
      if (pend) chk("mem_addr_stable", mem_addr, pend_addr);
      else begin
        pend = 1'b1;
        pend_addr = mem_addr;
        wcnt = int'($urandom_range(0, max_lat));
      end
      if (wcnt == 0) begin
        mem_ack = 1'b1;
        last_mem_cyc = cyc;
        a = int'(mem_addr);
        if (mem_rd) begin
          mem_din = 8'(sim_rd(a));
          if (exp_mr.size() == 0) chk("mr_unexpected", 1, 0);
          else chk("mr_addr", a, exp_mr.pop_front());
        end else begin
          sim_mem[a] = mem_dout;
          if (exp_mw.size() == 0) chk("mw_unexpected", 1, 0);
          else begin
            e = exp_mw.pop_front();
            chk("mw_addr", a, e.addr);
            chk("mw_data", mem_dout, e.data);
          end
        end
      end else wcnt--;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_sd_ack"}, sd_ack, 0);
    chk({tag, "_buff_addr"}, sd_buff_addr, 0);
    chk({tag, "_buff_dout"}, sd_buff_dout, 0);
    chk({tag, "_buff_wr"}, sd_buff_wr, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_mem_dout"}, mem_dout, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] lba,
                        input bit hold, input bit timed);
    bit oob;
    int rises0;
    int req_cyc;
    int t;
    model_req(!rd, lba, 32'(img_blocks), oob);
    @(negedge clk_sys);
    bw_count = 0;
    rises0 = ack_rises;
    req_cyc = cyc;
    sd_lba = lba;
    sd_rd = rd;
    sd_wr = wr;
    t = 0;
    while (!sd_ack && t < 20) begin
      @(negedge clk_sys);
      t++;
    end
    chk("ack_seen", sd_ack, 1);
    if (timed) chk("ack_latency", cyc - req_cyc, 2);
    if (hold) begin
      t = 0;
      while (bw_count < 512 && t < 20000) begin
        @(negedge clk_sys);
        t++;
      end
      repeat (4) @(negedge clk_sys);
      chk("hold_ack_high", sd_ack, 1);
      chk("hold_busy_high", busy, 1);
      sd_rd = 1'b0;
      sd_wr = 1'b0;
      @(negedge clk_sys);
      chk("hold_ack_fall", sd_ack, 0);
    end else begin
      sd_rd = 1'b0;
      sd_wr = 1'b0;
      sd_lba = $urandom;
    end
    t = 0;
    while (busy && t < 20000) begin
      @(negedge clk_sys);
      t++;
    end
    chk("done_busy_low", busy, 0);
    chk("done_ack_low", sd_ack, 0);
    chk("err", err, oob);
    chk("ack_pairs", ack_rises - rises0, 1);
    chk("bw_count", bw_count, rd ? 512 : 0);
    chk("bw_left", exp_bw.size(), 0);
    chk("mw_left", exp_mw.size(), 0);
    chk("mr_left", exp_mr.size(), 0);
    if (timed && rd) begin
      chk("rd_first_byte", first_bw_cyc - req_cyc, 4);
      chk("rd_last_byte", last_bw_cyc - req_cyc, 1026);
    end
    if (timed && !rd && !oob) chk("wr_last_byte", last_mem_cyc - req_cyc, 1537);
  endtask

  initial begin
    logic [31:0] l;
    int t;
    bit oob;
    for (int i = 0; i < 512; i++) bbuf[i] = 8'h00;
    repeat (3) @(negedge clk_sys);
    check_zero("reset");
    reset_n = 1'b1;
    img_blocks = 100;
    repeat (2) @(negedge clk_sys);

    do_req(1'b1, 1'b0, 32'd3, 1'b0, 1'b1);
    for (int i = 0; i < 512; i++) bbuf[i] = 8'(i);
    do_req(1'b0, 1'b1, 32'd1, 1'b0, 1'b1);
    for (int i = 0; i < 512; i++) chk("wr_image", sim_rd('h200 + i), i & 255);

    do_req(1'b1, 1'b0, 32'd100, 1'b0, 1'b1);
    img_blocks = 0;
    do_req(1'b0, 1'b1, 32'd1, 1'b0, 1'b0);
    img_blocks = 100;
    do_req(1'b1, 1'b0, 32'd1, 1'b0, 1'b0);

    max_lat = 7;
    for (int k = 0; k < 2; k++) begin
      l = 32'($urandom_range(0, 99));
      do_req(1'b1, 1'b0, l, 1'b0, 1'b0);
      for (int i = 0; i < 512; i++) bbuf[i] = 8'($urandom);
      do_req(1'b0, 1'b1, l, 1'b0, 1'b0);
      do_req(1'b1, 1'b0, l, 1'b0, 1'b0);
    end

    max_lat = 0;
    do_req(1'b1, 1'b1, 32'd10, 1'b1, 1'b0);
    do_req(1'b1, 1'b0, 32'd1, 1'b0, 1'b0);

    // Abort a read part-way through with reset.
    model_req(1'b0, 32'd7, 32'(img_blocks), oob);
    @(negedge clk_sys);
    bw_count = 0;
    sd_lba = 32'd7;
    sd_rd = 1'b1;
    t = 0;
    while (bw_count < 200 && t < 2000) begin
      @(negedge clk_sys);
      t++;
    end
    chk("abort_reached", bw_count >= 200, 1);
    sd_rd = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_zero("abort");
    exp_bw.delete();
    exp_mw.delete();
    exp_mr.delete();
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    do_req(1'b1, 1'b0, 32'd5, 1'b0, 1'b1);

    max_lat = 2;
    for (int k = 0; k < 3; k++) begin
      img_blocks = BLK_W'($urandom_range(1, 40));
      l = 32'($urandom_range(0, 60));
      if ($urandom_range(0, 1) == 0) do_req(1'b1, 1'b0, l, 1'b0, 1'b0);
      else do_req(1'b0, 1'b1, l, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", vectors, miscompares);
    $fatal(1);
  end
endmodule
